// File: rtl/inst_stream_encoder_if.sv
// Request, instruction-memory write and status signals between a program loader
// and inst_stream_encoder.
interface inst_stream_encoder_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_class;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [5:0]        in_func;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, in_valid, in_class, in_rs, in_rt, in_rd, in_func, in_imm, in_target,
        input  in_ready, im_we, im_addr, im_wdata, busy, done, err
    );

    modport slave (
        input  start, in_valid, in_class, in_rs, in_rt, in_rd, in_func, in_imm, in_target,
        output in_ready, im_we, im_addr, im_wdata, busy, done, err
    );
endinterface

// File: rtl/inst_stream_encoder.sv
// Encodes field-level instruction requests into 32-bit MIPS words, buffers them in a
// small FIFO and writes them to instruction memory sequentially from BASE_ADDR.
//
// state   | meaning
// S_IDLE  | no session open, waiting for start
// S_LOAD  | accepting requests, writing out buffered words
// S_DRAIN | halt accepted, writing out remaining words
// S_DONE  | session finished (halt written or memory overflow)
module inst_stream_encoder #(
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MEM_WORDS = 1024
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    inst_stream_encoder_if.slave bus_if
);

    localparam int unsigned    PTR_W   = $clog2(DEPTH);
    localparam int unsigned    IDX_W   = $clog2(MEM_WORDS + 1);
    localparam logic [PTR_W:0] PTR_ONE = 1;
    localparam logic [IDX_W-1:0] IDX_ONE = 1;
    localparam logic [3:0]     CLS_HALT = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       fifo_q [DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0] enc_word;
    logic        legal;
    logic        full, empty, in_ready, accept, push, pop, ovf;

    always_comb begin
        enc_word = '0;
        legal    = 1'b1;
        case (bus_if.in_class)
            4'd0: enc_word = {6'b000000, bus_if.in_rs, bus_if.in_rt, bus_if.in_rd, 5'b0, bus_if.in_func};
            4'd1: enc_word = {6'b100011, bus_if.in_rs, bus_if.in_rt, bus_if.in_imm};
            4'd2: enc_word = {6'b101011, bus_if.in_rs, bus_if.in_rt, bus_if.in_imm};
            4'd3: enc_word = {6'b000100, bus_if.in_rs, bus_if.in_rt, bus_if.in_imm};
            4'd4: enc_word = {6'b001001, bus_if.in_rs, bus_if.in_rt, bus_if.in_imm};
            4'd5: enc_word = {6'b000010, bus_if.in_target};
            4'd6: enc_word = {6'b000011, bus_if.in_target};
            4'd7: enc_word = {6'b000110, bus_if.in_rs, 21'b0};
            4'd8: enc_word = {6'b001010, bus_if.in_rs, bus_if.in_rt, bus_if.in_imm};
            4'd9: enc_word = {6'b111111, 26'b0};
            default: legal = 1'b0;
        endcase
    end

    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign in_ready = (state_q == S_LOAD) && !full;
    assign accept   = bus_if.in_valid && in_ready;
    assign push     = accept && legal;
    assign pop      = ((state_q == S_LOAD) || (state_q == S_DRAIN)) && !empty;
    assign ovf      = pop && (idx_q == IDX_W'(MEM_WORDS));

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        idx_d    = idx_q;
        err_d    = err_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus_if.start) begin
                    state_d  = S_LOAD;
                    err_d    = 1'b0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    idx_d    = '0;
                end
            end
            S_LOAD: begin
                if (accept && (bus_if.in_class == CLS_HALT)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (empty && !we_q) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            if (legal) wr_ptr_d = wr_ptr_q + PTR_ONE;
            else       err_d    = 1'b1;
        end

        // Overflow discards everything buffered, including a word pushed this cycle.
        if (ovf) begin
            err_d    = 1'b1;
            rd_ptr_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q;
            state_d  = S_DONE;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            we_d     = 1'b1;
            addr_d   = BASE_ADDR + (ADDR_W'(idx_q) << 2);
            wdata_d  = fifo_q[rd_ptr_q[PTR_W-1:0]];
            idx_d    = idx_q + IDX_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= BASE_ADDR;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Storage needs no reset; occupancy is defined by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= enc_word;
    end

    assign bus_if.in_ready = in_ready;
    assign bus_if.im_we    = we_q;
    assign bus_if.im_addr  = addr_q;
    assign bus_if.im_wdata = wdata_q;
    assign bus_if.busy     = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign bus_if.done     = (state_q == S_DONE);
    assign bus_if.err      = err_q;

endmodule

// File: tb/tb_inst_stream_encoder.sv
// Bench for inst_stream_encoder: table of encodings plus multi-cycle sequences,
// with a scoreboard of expected memory writes per instance.
module tb_inst_stream_encoder;

    localparam int unsigned ADDR_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inst_stream_encoder_if #(.ADDR_W(ADDR_W)) m_if ();
    inst_stream_encoder_if #(.ADDR_W(ADDR_W)) s_if ();

    inst_stream_encoder #(.DEPTH(4), .ADDR_W(ADDR_W), .BASE_ADDR(32'h0), .MEM_WORDS(1024)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_if (m_if)
    );

    inst_stream_encoder #(.DEPTH(4), .ADDR_W(ADDR_W), .BASE_ADDR(32'h0), .MEM_WORDS(4)) u_small (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_if (s_if)
    );

    typedef struct {
        logic [3:0]  cls;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  func;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] word;
        logic        legal;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_sq[$];
    vec_t tbl[12];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_idx = 0;
    int   run_len = 0;
    int   max_run = 0;
    int   s_writes = 0;

    function automatic vec_t mk(input logic [3:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [5:0] func, input logic [15:0] imm,
                                input logic [25:0] tgt, input logic [31:0] word, input logic legal);
        vec_t v;
        v.cls = cls; v.rs = rs; v.rt = rt; v.rd = rd; v.func = func;
        v.imm = imm; v.tgt = tgt; v.word = word; v.legal = legal;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
        end
    endtask

    task automatic send(input vec_t v);
        bit ok = 1'b0;
        m_if.in_class  = v.cls;
        m_if.in_rs     = v.rs;
        m_if.in_rt     = v.rt;
        m_if.in_rd     = v.rd;
        m_if.in_func   = v.func;
        m_if.in_imm    = v.imm;
        m_if.in_target = v.tgt;
        m_if.in_valid  = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (m_if.in_ready) begin
                ok = 1'b1;
                if (v.legal) begin
                    exp_q.push_back('{32'(exp_idx * 4), v.word});
                    exp_idx++;
                end
            end
            @(posedge clk); #1;
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start(input bit new_session);
        m_if.start = 1'b1;
        @(posedge clk); #1;
        m_if.start = 1'b0;
        if (new_session) exp_idx = 0;
    endtask

    task automatic wait_done(input string name, input logic exp_err);
        bit ok = 1'b0;
        m_if.in_valid = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (m_if.done) ok = 1'b1;
        end
        @(posedge clk); #1;
        chk({name, "_done"}, 32'(m_if.done), 32'd1);
        chk({name, "_err"}, 32'(m_if.err), 32'(exp_err));
        chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        tbl[0]  = mk(4'd1, 5'd0,  5'd8,  5'd0,  6'h00, 16'h0004, 26'h0,       32'h8C080004, 1'b1);
        tbl[1]  = mk(4'd0, 5'd1,  5'd2,  5'd3,  6'h20, 16'h0000, 26'h0,       32'h00221820, 1'b1);
        tbl[2]  = mk(4'd5, 5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h10,      32'h08000010, 1'b1);
        tbl[3]  = mk(4'd3, 5'd1,  5'd2,  5'd0,  6'h00, 16'hFFFF, 26'h0,       32'h1022FFFF, 1'b1);
        tbl[4]  = mk(4'd9, 5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h0,       32'hFC000000, 1'b1);
        tbl[5]  = mk(4'd2, 5'd29, 5'd31, 5'd0,  6'h00, 16'h0008, 26'h0,       32'hAFBF0008, 1'b1);
        tbl[6]  = mk(4'd4, 5'd0,  5'd1,  5'd0,  6'h00, 16'h0005, 26'h0,       32'h24010005, 1'b1);
        tbl[7]  = mk(4'd6, 5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF, 1'b1);
        tbl[8]  = mk(4'd7, 5'd31, 5'd5,  5'd9,  6'h2A, 16'h1234, 26'h2AAAAAA, 32'h1BE00000, 1'b1);
        tbl[9]  = mk(4'd8, 5'd2,  5'd3,  5'd0,  6'h00, 16'h8000, 26'h0,       32'h28438000, 1'b1);
        tbl[10] = mk(4'd0, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hABCD, 26'h1555555, 32'h03FFF83F, 1'b1);
        tbl[11] = mk(4'd9, 5'd7,  5'd7,  5'd7,  6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'hFC000000, 1'b1);

        rst_n = 1'b0;
        m_if.start = 1'b0; m_if.in_valid = 1'b0; m_if.in_class = '0; m_if.in_rs = '0; m_if.in_rt = '0;
        m_if.in_rd = '0; m_if.in_func = '0; m_if.in_imm = '0; m_if.in_target = '0;
        s_if.start = 1'b0; s_if.in_valid = 1'b0; s_if.in_class = '0; s_if.in_rs = '0; s_if.in_rt = '0;
        s_if.in_rd = '0; s_if.in_func = '0; s_if.in_imm = '0; s_if.in_target = '0;

        fork
            forever begin : mon_main
                exp_t e;
                @(negedge clk);
                if (rst_n && m_if.im_we) begin
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, wanted no write",
                                 m_if.im_addr, m_if.im_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", m_if.im_addr, e.addr);
                        chk("wr_data", m_if.im_wdata, e.word);
                    end
                end else begin
                    run_len = 0;
                end
            end
            forever begin : mon_small
                exp_t e;
                @(negedge clk);
                if (rst_n && s_if.im_we) begin
                    s_writes++;
                    if (exp_sq.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL small_unexpected_write: got addr 0x%08h, wanted no write", s_if.im_addr);
                    end else begin
                        e = exp_sq.pop_front();
                        chk("small_wr_addr", s_if.im_addr, e.addr);
                        chk("small_wr_data", s_if.im_wdata, e.word);
                    end
                end
            end
        join_none

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(m_if.in_ready), 32'd0);
        chk("rst_im_we",    32'(m_if.im_we),    32'd0);
        chk("rst_busy",     32'(m_if.busy),     32'd0);
        chk("rst_done",     32'(m_if.done),     32'd0);
        chk("rst_err",      32'(m_if.err),      32'd0);
        chk("rst_im_addr",  m_if.im_addr,       32'h0);
        chk("rst_im_wdata", m_if.im_wdata,      32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(m_if.in_ready), 32'd0);

        // Encoding table: each halt closes a session
        pulse_start(1'b1);
        chk("load_busy", 32'(m_if.busy), 32'd1);
        for (int i = 0; i < 12; i++) begin
            send(tbl[i]);
            if (tbl[i].cls == 4'd9) begin
                wait_done("table", 1'b0);
                if (i < 11) pulse_start(1'b1);
            end
        end

        // Sustained stream with in_valid held high
        pulse_start(1'b1);
        max_run = 0;
        for (int i = 0; i < 12; i++)
            send(mk(4'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'(16'h0100 + i), 26'd0, 32'h24010100 + 32'(i), 1'b1));
        send(tbl[4]);
        wait_done("burst", 1'b0);
        chk("burst_run", 32'(max_run), 32'd13);

        // Illegal class between two addi
        pulse_start(1'b1);
        send(mk(4'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0011, 26'd0, 32'h24010011, 1'b1));
        chk("err_before_illegal", 32'(m_if.err), 32'd0);
        send(mk(4'd12, 5'd1, 5'd1, 5'd1, 6'd1, 16'h0001, 26'd1, 32'h0, 1'b0));
        chk("err_after_illegal", 32'(m_if.err), 32'd1);
        send(mk(4'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0022, 26'd0, 32'h24010022, 1'b1));
        send(tbl[4]);
        wait_done("illegal", 1'b1);

        // start is honoured only in IDLE/DONE
        pulse_start(1'b1);
        chk("restart_err_cleared", 32'(m_if.err), 32'd0);
        chk("restart_done_low", 32'(m_if.done), 32'd0);
        send(mk(4'd4, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0033, 26'd0, 32'h24020033, 1'b1));
        send(mk(4'd15, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'd0, 32'h0, 1'b0));
        m_if.in_valid = 1'b0;
        pulse_start(1'b0);
        chk("load_start_err_kept", 32'(m_if.err), 32'd1);
        chk("load_start_busy", 32'(m_if.busy), 32'd1);
        send(mk(4'd4, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0044, 26'd0, 32'h24020044, 1'b1));
        send(tbl[4]);
        m_if.in_valid = 1'b0;
        pulse_start(1'b0);
        chk("drain_start_busy", 32'(m_if.busy), 32'd1);
        wait_done("ignored_start", 1'b1);
        pulse_start(1'b1);
        chk("done_start_err_cleared", 32'(m_if.err), 32'd0);
        send(tbl[4]);
        wait_done("restart", 1'b0);

        // Memory overflow on the 4-word instance
        s_if.start = 1'b1;
        @(posedge clk); #1;
        s_if.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_if.in_class = 4'd4;
            s_if.in_rt    = 5'd1;
            s_if.in_imm   = 16'(i);
            s_if.in_valid = 1'b1;
            @(negedge clk);
            chk("small_ready", 32'(s_if.in_ready), 32'd1);
            if (i < 4) exp_sq.push_back('{32'(i * 4), 32'h24010000 + 32'(i)});
            @(posedge clk); #1;
        end
        s_if.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("small_done", 32'(s_if.done), 32'd1);
        chk("small_err", 32'(s_if.err), 32'd1);
        chk("small_writes", 32'(s_writes), 32'd4);
        chk("small_left", 32'(exp_sq.size()), 32'd0);

        // Asynchronous reset in the middle of a stream
        pulse_start(1'b1);
        for (int i = 0; i < 3; i++)
            send(mk(4'd4, 5'd0, 5'd3, 5'd0, 6'd0, 16'(16'h0200 + i), 26'd0, 32'h24030200 + 32'(i), 1'b1));
        chk("pre_reset_we", 32'(m_if.im_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(m_if.im_we), 32'd0);
        chk("mid_rst_busy", 32'(m_if.busy), 32'd0);
        chk("mid_rst_done", 32'(m_if.done), 32'd0);
        chk("mid_rst_addr", m_if.im_addr, 32'h0);
        exp_q.delete();
        m_if.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(m_if.in_ready), 32'd0);
        pulse_start(1'b1);
        send(tbl[0]);
        send(tbl[4]);
        wait_done("after_reset", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
